// File: rtl/reservation_station_pkg.sv
// Shared constants, opcodes and entry types for the ALU reservation station.
// Also holds the CDB operand capture helper used by dispatch bypass and wakeup.
package reservation_station_pkg;

   localparam int DATA_WIDTH          = 32;
   localparam int ROB_TAG_WIDTH       = 5;
   localparam int INSIDE_OPCODE_WIDTH = 6;
   localparam int RS_SIZE             = 16;

   typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;
   typedef logic [DATA_WIDTH-1:0]    data_t;

   localparam rob_tag_t ZERO_TAG_ROB = '0;
   localparam data_t    ZERO_DATA    = '0;
   localparam logic     TRUE         = 1'b1;
   localparam logic     FALSE        = 1'b0;

   typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
      NOP = '0, LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
   } inside_op_e;

   // A value/tag pair: tag == 0 means value is valid; also used for a CDB broadcast.
   typedef struct packed {
      rob_tag_t tag;
      data_t    value;
   } tagged_t;

   typedef struct packed {
      logic [INSIDE_OPCODE_WIDTH-1:0] op;
      rob_tag_t                       rob_tag;
      tagged_t                        src1;
      tagged_t                        src2;
      data_t                          imm;
      data_t                          pc;
   } rs_entry_t;

   function automatic tagged_t capture(tagged_t opnd, tagged_t alu, tagged_t lsb);
      tagged_t res;
      res = opnd;
      if (opnd.tag != ZERO_TAG_ROB && opnd.tag == alu.tag) begin
         res = '{tag: ZERO_TAG_ROB, value: alu.value};
      end else if (opnd.tag != ZERO_TAG_ROB && opnd.tag == lsb.tag) begin
         res = '{tag: ZERO_TAG_ROB, value: lsb.value};
      end
      return res;
   endfunction

endpackage

// File: rtl/rs_priority_enc.sv
// Lowest-index-wins priority encoder: returns the index of the first set bit
// and a found flag.
module rs_priority_enc #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched micro-ops, captures CDB results
// and issues the lowest-index ready entry to the ALU each cycle.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE = reservation_station_pkg::RS_SIZE,
   parameter int IDX_W   = $clog2(RS_SIZE)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rdy,
   input  logic                           in_flush,
   input  logic [ROB_TAG_WIDTH-1:0]       in_decode_rob_tag,
   input  logic [INSIDE_OPCODE_WIDTH-1:0] in_decode_op,
   input  logic [DATA_WIDTH-1:0]          in_decode_value1,
   input  logic [DATA_WIDTH-1:0]          in_decode_value2,
   input  logic [ROB_TAG_WIDTH-1:0]       in_decode_tag1,
   input  logic [ROB_TAG_WIDTH-1:0]       in_decode_tag2,
   input  logic [DATA_WIDTH-1:0]          in_decode_imm,
   input  logic [DATA_WIDTH-1:0]          in_decode_pc,
   input  logic [ROB_TAG_WIDTH-1:0]       in_alu_cdb_tag,
   input  logic [DATA_WIDTH-1:0]          in_alu_cdb_value,
   input  logic [ROB_TAG_WIDTH-1:0]       in_lsb_cdb_tag,
   input  logic [DATA_WIDTH-1:0]          in_lsb_cdb_value,
   output logic                           out_full,
   output logic [ROB_TAG_WIDTH-1:0]       out_alu_rob_tag,
   output logic [INSIDE_OPCODE_WIDTH-1:0] out_alu_op,
   output logic [DATA_WIDTH-1:0]          out_alu_value1,
   output logic [DATA_WIDTH-1:0]          out_alu_value2,
   output logic [DATA_WIDTH-1:0]          out_alu_imm,
   output logic [DATA_WIDTH-1:0]          out_alu_pc
);

   logic [RS_SIZE-1:0] valid, valid_nxt, free_vec, ready_vec;
   rs_entry_t          entry     [RS_SIZE];
   rs_entry_t          entry_nxt [RS_SIZE];
   logic [IDX_W-1:0]   free_idx, issue_idx;
   logic               free_found, issue_found;
   logic               alloc_en, issue_en;
   tagged_t            alu_cdb, lsb_cdb;

   assign alu_cdb = '{tag: in_alu_cdb_tag, value: in_alu_cdb_value};
   assign lsb_cdb = '{tag: in_lsb_cdb_tag, value: in_lsb_cdb_value};

   // Free and ready vectors come from pre-edge state only.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         free_vec[i]  = ~valid[i];
         ready_vec[i] = valid[i] && entry[i].src1.tag == ZERO_TAG_ROB
                                 && entry[i].src2.tag == ZERO_TAG_ROB;
      end
   end

   rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_free_enc (
      .vec(free_vec), .idx(free_idx), .found(free_found)
   );

   rs_priority_enc #(.N(RS_SIZE), .W(IDX_W)) u_ready_enc (
      .vec(ready_vec), .idx(issue_idx), .found(issue_found)
   );

   assign alloc_en = rdy && !in_flush && in_decode_rob_tag != ZERO_TAG_ROB && free_found;
   assign issue_en = rdy && !in_flush && issue_found;

   always_comb begin
      valid_nxt = valid;
      if (rdy && in_flush) valid_nxt = '0;
      if (issue_en)        valid_nxt[issue_idx] = FALSE;
      if (alloc_en)        valid_nxt[free_idx]  = TRUE;
   end

   always_comb begin
      entry_nxt = entry;
      if (rdy && !in_flush) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (alloc_en && free_idx == IDX_W'(i)) begin
               entry_nxt[i].op      = in_decode_op;
               entry_nxt[i].rob_tag = in_decode_rob_tag;
               entry_nxt[i].src1    = capture('{tag: in_decode_tag1, value: in_decode_value1},
                                              alu_cdb, lsb_cdb);
               entry_nxt[i].src2    = capture('{tag: in_decode_tag2, value: in_decode_value2},
                                              alu_cdb, lsb_cdb);
               entry_nxt[i].imm     = in_decode_imm;
               entry_nxt[i].pc      = in_decode_pc;
            end else if (valid[i]) begin
               entry_nxt[i].src1 = capture(entry[i].src1, alu_cdb, lsb_cdb);
               entry_nxt[i].src2 = capture(entry[i].src2, alu_cdb, lsb_cdb);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= '0;
         out_full <= FALSE;
      end else begin
         valid    <= valid_nxt;
         out_full <= &valid_nxt;
      end
   end

   // NOTE: payload is not reset; valid bits alone decide whether an entry means anything.
   always_ff @(posedge clk) begin
      entry <= entry_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_alu_rob_tag <= ZERO_TAG_ROB;
         out_alu_op      <= NOP;
         out_alu_value1  <= ZERO_DATA;
         out_alu_value2  <= ZERO_DATA;
         out_alu_imm     <= ZERO_DATA;
         out_alu_pc      <= ZERO_DATA;
      end else if (!issue_en) begin
         out_alu_rob_tag <= ZERO_TAG_ROB;
         out_alu_op      <= NOP;
      end else begin
         out_alu_rob_tag <= entry[issue_idx].rob_tag;
         out_alu_op      <= entry[issue_idx].op;
         out_alu_value1  <= entry[issue_idx].src1.value;
         out_alu_value2  <= entry[issue_idx].src2.value;
         out_alu_imm     <= entry[issue_idx].imm;
         out_alu_pc      <= entry[issue_idx].pc;
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: dispatch, wakeup, bypass, full,
// flush, rdy stall and asynchronous reset scenarios.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic                           clk;
   logic                           rst;
   logic                           rdy;
   logic                           in_flush;
   logic [ROB_TAG_WIDTH-1:0]       in_decode_rob_tag;
   logic [INSIDE_OPCODE_WIDTH-1:0] in_decode_op;
   logic [DATA_WIDTH-1:0]          in_decode_value1, in_decode_value2;
   logic [ROB_TAG_WIDTH-1:0]       in_decode_tag1, in_decode_tag2;
   logic [DATA_WIDTH-1:0]          in_decode_imm, in_decode_pc;
   logic [ROB_TAG_WIDTH-1:0]       in_alu_cdb_tag, in_lsb_cdb_tag;
   logic [DATA_WIDTH-1:0]          in_alu_cdb_value, in_lsb_cdb_value;
   logic                           out_full;
   logic [ROB_TAG_WIDTH-1:0]       out_alu_rob_tag;
   logic [INSIDE_OPCODE_WIDTH-1:0] out_alu_op;
   logic [DATA_WIDTH-1:0]          out_alu_value1, out_alu_value2, out_alu_imm, out_alu_pc;

   int n_cmp = 0;
   int n_err = 0;

   reservation_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .in_flush(in_flush),
      .in_decode_rob_tag(in_decode_rob_tag), .in_decode_op(in_decode_op),
      .in_decode_value1(in_decode_value1), .in_decode_value2(in_decode_value2),
      .in_decode_tag1(in_decode_tag1), .in_decode_tag2(in_decode_tag2),
      .in_decode_imm(in_decode_imm), .in_decode_pc(in_decode_pc),
      .in_alu_cdb_tag(in_alu_cdb_tag), .in_alu_cdb_value(in_alu_cdb_value),
      .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_value(in_lsb_cdb_value),
      .out_full(out_full), .out_alu_rob_tag(out_alu_rob_tag), .out_alu_op(out_alu_op),
      .out_alu_value1(out_alu_value1), .out_alu_value2(out_alu_value2),
      .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_flush          = 1'b0;
      in_decode_rob_tag = '0;
      in_decode_op      = NOP;
      in_decode_value1  = '0;
      in_decode_value2  = '0;
      in_decode_tag1    = '0;
      in_decode_tag2    = '0;
      in_decode_imm     = '0;
      in_decode_pc      = '0;
      in_alu_cdb_tag    = '0;
      in_alu_cdb_value  = '0;
      in_lsb_cdb_tag    = '0;
      in_lsb_cdb_value  = '0;
   endtask

   task automatic dispatch(input logic [4:0] tag, input logic [5:0] op,
                           input logic [31:0] v1, input logic [31:0] v2,
                           input logic [4:0] t1, input logic [4:0] t2,
                           input logic [31:0] imm, input logic [31:0] pc);
      in_decode_rob_tag = tag;
      in_decode_op      = op;
      in_decode_value1  = v1;
      in_decode_value2  = v2;
      in_decode_tag1    = t1;
      in_decode_tag2    = t2;
      in_decode_imm     = imm;
      in_decode_pc      = pc;
   endtask

   task automatic cdb(input logic [4:0] at, input logic [31:0] av,
                      input logic [4:0] lt, input logic [31:0] lv);
      in_alu_cdb_tag   = at;
      in_alu_cdb_value = av;
      in_lsb_cdb_tag   = lt;
      in_lsb_cdb_value = lv;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rdy = 1'b1;
      idle_inputs();
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL reset_tag: got %h expected 0", out_alu_rob_tag); end
      n_cmp++; if (out_alu_op !== NOP) begin n_err++; $display("FAIL reset_op: got %h expected %h", out_alu_op, NOP); end
      n_cmp++; if (out_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", out_full); end
      n_cmp++; if (out_alu_value1 !== 32'd0) begin n_err++; $display("FAIL reset_v1: got %h expected 0", out_alu_value1); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      dispatch(5'd3, ADD, 32'd5, 32'd7, 5'd0, 5'd0, 32'h100, 32'h8000_0000);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL basic_alloc_edge: got %0d expected 0", out_alu_rob_tag); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd3) begin n_err++; $display("FAIL basic_tag: got %0d expected 3", out_alu_rob_tag); end
      n_cmp++; if (out_alu_op !== ADD) begin n_err++; $display("FAIL basic_op: got %0d expected %0d", out_alu_op, ADD); end
      n_cmp++; if (out_alu_value1 !== 32'd5) begin n_err++; $display("FAIL basic_v1: got %h expected 5", out_alu_value1); end
      n_cmp++; if (out_alu_value2 !== 32'd7) begin n_err++; $display("FAIL basic_v2: got %h expected 7", out_alu_value2); end
      n_cmp++; if (out_alu_imm !== 32'h100) begin n_err++; $display("FAIL basic_imm: got %h expected 100", out_alu_imm); end
      n_cmp++; if (out_alu_pc !== 32'h8000_0000) begin n_err++; $display("FAIL basic_pc: got %h expected 80000000", out_alu_pc); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL basic_idle_tag: got %0d expected 0", out_alu_rob_tag); end
      n_cmp++; if (out_alu_op !== NOP) begin n_err++; $display("FAIL basic_idle_op: got %0d expected 0", out_alu_op); end
   endtask

   task automatic test_wakeup();
      dispatch(5'd4, SUB, 32'hdead, 32'd1, 5'd2, 5'd0, 32'd0, 32'h10);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL wake_wait0: got %0d expected 0", out_alu_rob_tag); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL wake_wait1: got %0d expected 0", out_alu_rob_tag); end
      cdb(5'd2, 32'h10, 5'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL wake_early: got %0d expected 0", out_alu_rob_tag); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd4) begin n_err++; $display("FAIL wake_tag: got %0d expected 4", out_alu_rob_tag); end
      n_cmp++; if (out_alu_op !== SUB) begin n_err++; $display("FAIL wake_op: got %0d expected %0d", out_alu_op, SUB); end
      n_cmp++; if (out_alu_value1 !== 32'h10) begin n_err++; $display("FAIL wake_v1: got %h expected 10", out_alu_value1); end
      n_cmp++; if (out_alu_value2 !== 32'd1) begin n_err++; $display("FAIL wake_v2: got %h expected 1", out_alu_value2); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL wake_after: got %0d expected 0", out_alu_rob_tag); end
   endtask

   task automatic test_dual_bypass();
      dispatch(5'd5, ADD, 32'hffff, 32'heeee, 5'd6, 5'd7, 32'd0, 32'd0);
      cdb(5'd6, 32'd1, 5'd7, 32'd2);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL bypass_alloc_edge: got %0d expected 0", out_alu_rob_tag); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd5) begin n_err++; $display("FAIL bypass_tag: got %0d expected 5", out_alu_rob_tag); end
      n_cmp++; if (out_alu_value1 !== 32'd1) begin n_err++; $display("FAIL bypass_v1: got %h expected 1", out_alu_value1); end
      n_cmp++; if (out_alu_value2 !== 32'd2) begin n_err++; $display("FAIL bypass_v2: got %h expected 2", out_alu_value2); end
      tick();
   endtask

   task automatic test_full();
      logic exp_full;
      logic [4:0] exp_tag;
      for (int i = 0; i < 16; i++) begin
         dispatch(5'(10 + i), ADD, 32'(i), 32'd0, 5'd9, 5'd0, 32'd0, 32'd0);
         tick();
         exp_full = (i == 15);
         n_cmp++; if (out_full !== exp_full) begin n_err++; $display("FAIL fill_full[%0d]: got %b expected %b", i, out_full, exp_full); end
      end
      dispatch(5'd26, ADD, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_full !== 1'b1) begin n_err++; $display("FAIL overflow_full: got %b expected 1", out_full); end
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL overflow_tag: got %0d expected 0", out_alu_rob_tag); end
      cdb(5'd9, 32'h99, 5'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL full_wake_edge: got %0d expected 0", out_alu_rob_tag); end
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_tag = 5'(10 + k);
         n_cmp++; if (out_alu_rob_tag !== exp_tag) begin n_err++; $display("FAIL drain_tag[%0d]: got %0d expected %0d", k, out_alu_rob_tag, exp_tag); end
         n_cmp++; if (out_alu_value1 !== 32'h99) begin n_err++; $display("FAIL drain_v1[%0d]: got %h expected 99", k, out_alu_value1); end
         n_cmp++; if (out_full !== 1'b0) begin n_err++; $display("FAIL drain_full[%0d]: got %b expected 0", k, out_full); end
      end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL overflow_stored: got %0d expected 0", out_alu_rob_tag); end
   endtask

   task automatic test_flush();
      dispatch(5'd11, ADD, 32'd1, 32'd1, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
      dispatch(5'd12, ADD, 32'd2, 32'd2, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd11) begin n_err++; $display("FAIL flush_pre11: got %0d expected 11", out_alu_rob_tag); end
      dispatch(5'd13, ADD, 32'd3, 32'd3, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd12) begin n_err++; $display("FAIL flush_pre12: got %0d expected 12", out_alu_rob_tag); end
      dispatch(5'd14, ADD, 32'd4, 32'd4, 5'd0, 5'd0, 32'd0, 32'd0);
      in_flush = 1'b1;
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL flush_tag: got %0d expected 0", out_alu_rob_tag); end
      n_cmp++; if (out_full !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b expected 0", out_full); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL flush_after[%0d]: got %0d expected 0", k, out_alu_rob_tag); end
      end
   endtask

   task automatic test_rdy();
      dispatch(5'd20, ADD, 32'd3, 32'd4, 5'd0, 5'd0, 32'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL rdy_alloc_edge: got %0d expected 0", out_alu_rob_tag); end
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL rdy_stall[%0d]: got %0d expected 0", k, out_alu_rob_tag); end
      end
      rdy = 1'b1;
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd20) begin n_err++; $display("FAIL rdy_resume_tag: got %0d expected 20", out_alu_rob_tag); end
      n_cmp++; if (out_alu_value2 !== 32'd4) begin n_err++; $display("FAIL rdy_resume_v2: got %h expected 4", out_alu_value2); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL rdy_after: got %0d expected 0", out_alu_rob_tag); end
   endtask

   task automatic test_async_reset();
      dispatch(5'd21, SLT, 32'ha, 32'hb, 5'd0, 5'd0, 32'hc, 32'hd);
      tick();
      dispatch(5'd22, ADD, 32'd0, 32'd0, 5'd9, 5'd0, 32'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd21) begin n_err++; $display("FAIL areset_pre_tag: got %0d expected 21", out_alu_rob_tag); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL areset_tag: got %0d expected 0", out_alu_rob_tag); end
      n_cmp++; if (out_alu_op !== NOP) begin n_err++; $display("FAIL areset_op: got %0d expected 0", out_alu_op); end
      n_cmp++; if (out_alu_value1 !== 32'd0) begin n_err++; $display("FAIL areset_v1: got %h expected 0", out_alu_value1); end
      n_cmp++; if (out_alu_value2 !== 32'd0) begin n_err++; $display("FAIL areset_v2: got %h expected 0", out_alu_value2); end
      n_cmp++; if (out_alu_imm !== 32'd0) begin n_err++; $display("FAIL areset_imm: got %h expected 0", out_alu_imm); end
      n_cmp++; if (out_alu_pc !== 32'd0) begin n_err++; $display("FAIL areset_pc: got %h expected 0", out_alu_pc); end
      n_cmp++; if (out_full !== 1'b0) begin n_err++; $display("FAIL areset_full: got %b expected 0", out_full); end
      rst = 1'b1;
      cdb(5'd9, 32'h55, 5'd0, 32'd0);
      tick();
      idle_inputs();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL areset_cleared0: got %0d expected 0", out_alu_rob_tag); end
      tick();
      n_cmp++; if (out_alu_rob_tag !== 5'd0) begin n_err++; $display("FAIL areset_cleared1: got %0d expected 0", out_alu_rob_tag); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_dual_bypass();
      test_full();
      test_flush();
      test_rdy();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
